// File: rtl/sample_capture_ctrl.sv
// Capture controller: streams a bounded number of ADC samples into memory port A,
// one registered write per accepted sample, then reports completion until restarted.
module sample_capture_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   num_samples,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   samples_written
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_TARGET = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   target_q;
  logic [ADDR_WIDTH:0]   new_target;
  logic [ADDR_WIDTH:0]   sw_inc;
  logic                  accept;
  logic                  start_ok;

  // Any request with the top bit set is at least 2^ADDR_WIDTH, so clamp it to the memory depth.
  assign new_target = num_samples[ADDR_WIDTH] ? MAX_TARGET : num_samples;
  assign sw_inc     = samples_written + ONE;
  assign accept     = s_valid && s_ready;
  assign start_ok   = start && !abort && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = (new_target == '0) ? DONE : CAPTURE;
        CAPTURE:    if (accept && sw_inc == target_q) state_d = FLUSH;
        FLUSH:      state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      CAPTURE: begin
        s_ready = !abort;
        busy    = 1'b1;
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_en       <= 1'b0;
      mem_addr        <= '0;
      mem_wr_data     <= '0;
      samples_written <= '0;
      target_q        <= '0;
    end else begin
      mem_wr_en <= accept;
      if (start_ok) begin
        target_q        <= new_target;
        samples_written <= '0;
      end else if (accept) begin
        samples_written <= sw_inc;
        mem_addr        <= samples_written[ADDR_WIDTH-1:0];
        mem_wr_data     <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Bench for sample_capture_ctrl: directed scenarios plus random traffic, each cycle
// compared with a capture-level reference model.
module tb_sample_capture_ctrl;

  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int MAXT = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic          busy;
  logic          done;
  logic [AW:0]   samples_written;

  int checks   = 0;
  int failures = 0;

  // Reference model: capture phase flags, target, count and the expected write port.
  bit m_cap, m_flush, m_done, m_wr;
  int m_target, m_count, m_addr, m_data;

  sample_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .busy(busy), .done(done),
    .samples_written(samples_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_flush = 0; m_done = 0; m_wr = 0;
    m_target = 0; m_count = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic check_outputs();
    chk("mem_wr_en", mem_wr_en, m_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wr_data", mem_wr_data, m_data);
    chk("samples_written", samples_written, m_count);
    chk("busy", busy, m_cap || m_flush);
    chk("done", done, m_done);
  endtask

  task automatic step(input bit st, input bit ab, input int ns, input bit sv, input logic [DW-1:0] sd);
    bit acc;
    start = st; abort = ab; num_samples = ns[AW:0]; s_valid = sv; s_data = sd;
    #1;
    chk("s_ready", s_ready, m_cap && !ab);
    acc = m_cap && !ab && sv;
    @(posedge clk); #1;
    m_wr = acc;
    if (acc) begin
      m_addr = m_count; m_data = sd; m_count++;
    end
    if (ab) begin
      m_cap = 0; m_flush = 0; m_done = 0;
    end else if (!m_cap && !m_flush && st) begin
      m_target = (ns > MAXT) ? MAXT : ns;
      m_count  = 0;
      m_done   = (m_target == 0);
      m_cap    = (m_target != 0);
    end else if (m_flush) begin
      m_flush = 0; m_done = 1;
    end else if (acc && m_count == m_target) begin
      m_cap = 0; m_flush = 1;
    end
    check_outputs();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, '0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_outputs();
    chk("s_ready_rst", s_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // four back-to-back samples
    step(1, 0, 4, 0, '0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, 1, DW'(16'hA0 + i));
    idle_step(); idle_step();

    // gapped valid
    step(1, 0, 3, 0, '0);
    for (int unsigned i = 0; i < 5; i++) step(0, 0, 0, (i % 2) == 0, DW'(16'hB0 + i));
    idle_step(); idle_step();

    // abort after two of eight
    step(1, 0, 8, 0, '0);
    step(0, 0, 0, 1, 16'hC0);
    step(0, 0, 0, 1, 16'hC1);
    step(0, 1, 0, 1, 16'hC2);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1, DW'(16'hC3 + i));

    // zero length, then oversize length
    step(1, 0, 0, 1, 16'hD0);
    idle_step();
    step(1, 0, MAXT + 5, 0, '0);
    for (int unsigned i = 0; i < MAXT + 2; i++) step(0, 0, 0, 1, DW'($urandom));
    idle_step();

    // start with abort in IDLE, then start ignored while capturing
    step(0, 1, 0, 0, '0);
    step(1, 1, 5, 0, '0);
    idle_step();
    step(1, 0, 5, 0, '0);
    step(0, 0, 0, 1, 16'hE0);
    step(1, 0, 2, 1, 16'hE1);
    step(1, 0, 0, 0, '0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, 1, DW'(16'hE2 + i));

    // reset in the middle of a capture
    step(1, 0, 10, 0, '0);
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 1, DW'(16'hF0 + i));
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("s_ready_rst_mid", s_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, 1, DW'(16'hF8 + i));

    // random traffic
    for (int unsigned i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
           int'($urandom_range(0, MAXT + 3)), $urandom_range(0, 9) < 7, DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
SAMPLE_CAPTURE_CTRL -- requirements
Module: sample_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample and memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a capture.
REQ-006 SHALL have port abort  input  1  cancels the capture in progress; returns to IDLE.
REQ-007 SHALL have port num_samples  input  ADDR_WIDTH+1  capture length, sampled only on an accepted start.
REQ-008 SHALL have port s_valid  input  1  upstream ADC sample valid.
REQ-009 SHALL have port s_data  input  DATA_WIDTH  upstream ADC sample.
REQ-010 SHALL have port s_ready  output  1  sample accepted on the edge where s_valid && s_ready.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  memory port-A address, registered.
REQ-012 SHALL have port mem_wr_data  output  DATA_WIDTH  memory port-A write data, registered.
REQ-013 SHALL have port mem_wr_en  output  1  memory port-A write enable, registered, one cycle per sample.
REQ-014 SHALL have port busy  output  1  high in CAPTURE or FLUSH.
REQ-015 SHALL have port done  output  1  high in DONE; capture complete and committed to memory.
REQ-016 SHALL have port samples_written  output  ADDR_WIDTH+1  count of samples accepted in the current/last capture.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, FLUSH, DONE.
REQ-018 SHALL latch target = min(num_samples, 2^ADDR_WIDTH) and clear samples_written to 0 on start in IDLE or DONE.
REQ-019 SHALL go IDLE/DONE -> CAPTURE on start with target != 0; with target == 0, go to DONE with samples_written = 0.
REQ-020 SHALL ignore start while in CAPTURE or FLUSH.
REQ-021 SHALL drive s_ready = (state == CAPTURE) && !abort, combinationally; samples presented in other states are dropped.
REQ-022 SHALL, on each accepted sample, register mem_wr_en = 1, mem_addr = samples_written[ADDR_WIDTH-1:0], mem_wr_data = s_data, and increment samples_written, all on the same edge.
REQ-023 SHALL drive mem_wr_en = 0 in every cycle not immediately following an accepted sample; back-to-back samples produce back-to-back writes at consecutive addresses.
REQ-024 SHALL go CAPTURE -> FLUSH on the edge accepting sample number target (samples_written reaches target).
REQ-025 SHALL go FLUSH -> DONE unconditionally on the next edge, so done rises one cycle after the last mem_wr_en pulse.
REQ-026 SHALL hold DONE, done = 1, and samples_written until start or abort.
REQ-027 SHALL, on abort in any state, go to IDLE on the next edge, with mem_wr_en = 0 from that edge; a write already registered completes; samples_written holds its value.
REQ-028 SHALL give abort priority over start and over sample acceptance when asserted in the same cycle.
REQ-029 SHALL, for target = 2^ADDR_WIDTH, write addresses 0 .. 2^ADDR_WIDTH-1 with no address wrap, and reach samples_written = 2^ADDR_WIDTH.
REQ-030 SHALL not stall on memory; one write per cycle is always sustainable.

Reset
REQ-031 SHALL, on rst high, immediately set state IDLE, mem_wr_en 0, mem_addr 0, mem_wr_data 0, samples_written 0, busy 0, done 0; s_ready is 0.
REQ-032 SHALL, on rst during CAPTURE or FLUSH, abandon the capture with no further writes after reset release until a new start.

Verification
REQ-033 SHALL cover: start with num_samples = 4 and s_valid continuously high, data 0xA0..0xA3 -> writes at addr 0..3 on four consecutive cycles; done high one cycle after the last write; samples_written = 4.
REQ-034 SHALL cover: num_samples = 3 with s_valid gapped (1,0,1,0,1) -> exactly 3 writes at addr 0,1,2; no write in gap cycles.
REQ-035 SHALL cover: abort after 2 of 8 samples -> IDLE, no further mem_wr_en, samples_written = 2, done = 0.
REQ-036 SHALL cover: start with num_samples = 0 -> DONE next cycle, no writes; and num_samples = 2^ADDR_WIDTH+5 -> exactly 2^ADDR_WIDTH writes, final addr = 2^ADDR_WIDTH-1.
REQ-037 SHALL cover: start and abort asserted together in IDLE -> remains IDLE; start asserted in CAPTURE -> ignored, count unaffected.
REQ-038 SHALL cover: rst asserted mid-capture -> outputs reach reset values without a clock edge; no writes until a new start.
